prog_seq_ctrl: RTL and testbench

- Instruction sequencer for the single-cycle core. Owns the program counter and run state, and turns the ALU's branch, reset and halt outputs into next-PC decisions.
- Provides the Start/Ack handshake to the testbench/top level, and a cycle counter for performance checks.
- Sits between the ALU outputs (bOFFSET, bSIGN, reset, halt) and the instruction ROM address input.

---
 rtl/prog_seq_ctrl.sv | 95 +++++++++
 tb/tb_prog_seq_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/prog_seq_ctrl.sv
// Instruction sequencer: owns the program counter, run state and RUN-cycle counter.
// Turns the ALU's branch, soft-reset and halt outputs into next-PC decisions.
module prog_seq_ctrl #(
  parameter int unsigned PC_W       = 10,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Branch,
  input  logic [3:0]       bOFFSET,
  input  logic             bSIGN,
  input  logic             SoftReset,
  input  logic             HaltReq,
  input  logic             Stall,
  output logic [PC_W-1:0]  PC,
  output logic             InstrValid,
  output logic             Ack,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [1:0]       State
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10,
    S_BAD  = 2'b11
  } state_t;

  localparam logic [PC_W-1:0]  START_PC = PC_W'(START_ADDR);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t          state_q;
  logic [PC_W-1:0] offset_ext;

  assign offset_ext = PC_W'(bOFFSET);
  assign State      = state_q;

  // Sequencer FSM; PC and counter arithmetic wrap/saturate in the register update.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      PC         <= START_PC;
      InstrValid <= 1'b0;
      Ack        <= 1'b0;
      CycleCnt   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          PC <= START_PC;
          if (Start) begin
            state_q    <= S_RUN;
            InstrValid <= 1'b1;
            CycleCnt   <= '0;
          end
        end
        S_RUN: begin
          if (CycleCnt != CNT_MAX) CycleCnt <= CycleCnt + CNT_W'(1);
          if (Stall) begin
            PC <= PC;
          end else if (HaltReq) begin
            state_q    <= S_DONE;
            InstrValid <= 1'b0;
            Ack        <= 1'b1;
          end else if (SoftReset) begin
            PC <= START_PC;
          end else if (Branch) begin
            PC <= bSIGN ? (PC - offset_ext) : (PC + offset_ext);
          end else begin
            PC <= PC + PC_W'(1);
          end
        end
        S_DONE: begin
          if (Start) begin
            state_q    <= S_RUN;
            PC         <= START_PC;
            CycleCnt   <= '0;
            InstrValid <= 1'b1;
            Ack        <= 1'b0;
          end
        end
        default: begin
          // Unused encoding falls back to a clean IDLE.
          state_q    <= S_IDLE;
          PC         <= START_PC;
          InstrValid <= 1'b0;
          Ack        <= 1'b0;
          CycleCnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_seq_ctrl.sv
// Bench for prog_seq_ctrl: directed scenarios plus randomized traffic, checked every
// cycle against a behavioural model of the sequencer rules.
module tb_prog_seq_ctrl;

  localparam int unsigned PC_W  = 10;
  localparam int unsigned CNT_W = 16;
  localparam int PC_MOD  = 1 << PC_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             Clk;
  logic             Reset;
  logic             Start;
  logic             Branch;
  logic [3:0]       bOFFSET;
  logic             bSIGN;
  logic             SoftReset;
  logic             HaltReq;
  logic             Stall;
  logic [PC_W-1:0]  PC;
  logic             InstrValid;
  logic             Ack;
  logic [CNT_W-1:0] CycleCnt;
  logic [1:0]       State;

  int errors = 0;
  int checks = 0;

  // Model: 0 idle, 1 run, 2 done
  int m_st  = 0;
  int m_pc  = 0;
  int m_cnt = 0;

  prog_seq_ctrl #(.PC_W(PC_W), .START_ADDR(0), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Branch(Branch), .bOFFSET(bOFFSET),
    .bSIGN(bSIGN), .SoftReset(SoftReset), .HaltReq(HaltReq), .Stall(Stall),
    .PC(PC), .InstrValid(InstrValid), .Ack(Ack), .CycleCnt(CycleCnt), .State(State)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_pc = 0; m_cnt = 0;
  endtask

  // One clock edge of the sequencer rules, using the inputs as sampled.
  task automatic model_edge();
    int delta;
    case (m_st)
      0: if (Start) begin m_st = 1; m_cnt = 0; m_pc = 0; end
      1: begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (Stall) ;
        else if (HaltReq) m_st = 2;
        else if (SoftReset) m_pc = 0;
        else begin
          delta = Branch ? (bSIGN ? -int'(bOFFSET) : int'(bOFFSET)) : 1;
          m_pc = (m_pc + delta + PC_MOD) % PC_MOD;
        end
      end
      default: if (Start) begin m_st = 1; m_pc = 0; m_cnt = 0; end
    endcase
  endtask

  // Apply inputs after a falling edge, take one rising edge, return at the next falling edge.
  task automatic step(input logic st, input logic br, input int off, input logic sg,
                      input logic sr, input logic hr, input logic stl);
    Start = st; Branch = br; bOFFSET = 4'(off); bSIGN = sg;
    SoftReset = sr; HaltReq = hr; Stall = stl;
    @(posedge Clk);
    if (!Reset) model_edge();
    @(negedge Clk);
  endtask

  task automatic plain(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Every falling edge: outputs must equal the model.
  always @(negedge Clk) begin
    chk("state", int'(State), m_st);
    chk("pc", int'(PC), m_pc);
    chk("instr_valid", int'(InstrValid), int'(m_st == 1));
    chk("ack", int'(Ack), int'(m_st == 2));
    chk("cycle_cnt", int'(CycleCnt), m_cnt);
  end

  initial begin
    int cnt0;
    Reset = 1'b1;
    Start = 0; Branch = 0; bOFFSET = 0; bSIGN = 0; SoftReset = 0; HaltReq = 0; Stall = 0;
    model_reset();
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    step(0, 1, 7, 0, 1, 1, 0);
    step(0, 1, 3, 1, 0, 0, 0);
    chk("idle_pc", int'(PC), 0);
    chk("idle_state", int'(State), 0);

    // Start and plain increments
    step(1, 0, 0, 0, 0, 0, 0);
    chk("start_state", int'(State), 1);
    chk("start_pc", int'(PC), 0);
    chk("start_cnt", int'(CycleCnt), 0);
    plain(3);
    chk("inc_pc3", int'(PC), 3);
    chk("inc_cnt3", int'(CycleCnt), 3);
    plain(5);
    chk("inc_pc8", int'(PC), 8);

    // Branches
    step(0, 1, 5, 1, 0, 0, 0);
    chk("br_back5", int'(PC), 3);
    step(0, 1, 15, 0, 0, 0, 0);
    chk("br_fwd15", int'(PC), 18);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("br_zero", int'(PC), 18);

    // Wrap-around both directions
    step(0, 0, 0, 0, 1, 0, 0);
    chk("soft_to_0", int'(PC), 0);
    step(0, 1, 1, 1, 0, 0, 0);
    chk("wrap_back", int'(PC), 1023);
    plain(1);
    chk("wrap_fwd", int'(PC), 0);
    plain(2);
    step(0, 1, 4, 1, 0, 0, 0);
    chk("wrap_back4", int'(PC), 1022);

    // Stall has top priority; counter still runs
    cnt0 = int'(CycleCnt);
    repeat (3) step(1, 1, 9, 0, 1, 1, 1);
    chk("stall_pc", int'(PC), 1022);
    chk("stall_state", int'(State), 1);
    chk("stall_cnt", int'(CycleCnt), cnt0 + 3);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("halt_state", int'(State), 2);
    chk("halt_ack", int'(Ack), 1);
    chk("halt_pc", int'(PC), 1022);
    chk("halt_cnt", int'(CycleCnt), cnt0 + 4);
    step(0, 1, 3, 0, 1, 0, 0);
    chk("done_hold_pc", int'(PC), 1022);

    // Restart, soft reset, soft+halt
    step(1, 0, 0, 0, 0, 0, 0);
    chk("restart_pc", int'(PC), 0);
    chk("restart_cnt", int'(CycleCnt), 0);
    chk("restart_ack", int'(Ack), 0);
    plain(40);
    chk("pc40", int'(PC), 40);
    step(0, 1, 2, 0, 1, 0, 0);
    chk("soft_pc", int'(PC), 0);
    chk("soft_state", int'(State), 1);
    step(0, 0, 0, 0, 1, 1, 0);
    chk("soft_halt_state", int'(State), 2);
    chk("soft_halt_pc", int'(PC), 0);
    step(1, 0, 0, 0, 0, 0, 0);
    plain(77);
    chk("pc77", int'(PC), 77);

    // Async reset between edges
    #2 Reset = 1'b1;
    #1;
    model_reset();
    chk("areset_pc", int'(PC), 0);
    chk("areset_state", int'(State), 0);
    chk("areset_ack", int'(Ack), 0);
    chk("areset_cnt", int'(CycleCnt), 0);
    chk("areset_valid", int'(InstrValid), 0);
    @(negedge Clk);
    Reset = 1'b0;
    step(0, 1, 6, 0, 0, 0, 0);
    plain(2);
    chk("post_reset_pc", int'(PC), 0);
    chk("post_reset_state", int'(State), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 1)),
           int'($urandom_range(0, 15)), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 15) == 0), logic'($urandom_range(0, 24) == 0),
           logic'($urandom_range(0, 4) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
